o_pixel_packer: RTL and testbench

//   Consumes the scope-domain pixel coordinates (O_X, O_Y, O_VISIBLE) from the

---
 rtl/o_pixel_packer.sv | 194 +++++++++++++++++++
 tb/tb_o_pixel_packer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/o_pixel_packer.sv
// Packs 16 horizontally adjacent 1-bit scope pixels into frame-buffer words,
// queues {address, word} in an 8-deep FIFO and drains it over a REQ/ACK handshake.
module o_pixel_packer (
  input  logic        o_clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [9:0]  o_x_i,
  input  logic [8:0]  o_y_i,
  input  logic        o_visible_i,
  input  logic        o_data_i,
  output logic        wr_req_o,
  output logic [13:0] wr_addr_o,
  output logic [15:0] wr_data_o,
  input  logic        wr_ack_i,
  output logic [3:0]  fifo_level_o,
  output logic        overflow_o,
  output logic        frame_done_o
);

  localparam int ADDR_W     = 14;
  localparam int WORD_W     = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  localparam logic [9:0]        H_VISIBLE = 10'd576;
  localparam logic [8:0]        V_VISIBLE = 9'd378;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 14'd13607;
  localparam logic [3:0]        FULL_LVL  = 4'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Pixel packing and staging of completed words
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] pack_q, pack_d;
  logic              stage_v_q, stage_v_d;
  logic [ADDR_W-1:0] stage_addr_q, stage_addr_d;
  logic [WORD_W-1:0] stage_data_q, stage_data_d;

  logic              capture;
  logic              in_range;
  logic [ADDR_W-1:0] word_addr;

  assign capture  = enable_i & o_visible_i;
  assign in_range = (o_x_i < H_VISIBLE) && (o_y_i < V_VISIBLE);

  // y*36 + x/16 without a multiplier.
  assign word_addr = ADDR_W'({o_y_i, 5'b0_0000}) + ADDR_W'({o_y_i, 2'b00})
                   + ADDR_W'(o_x_i[9:4]);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pack_d       = pack_q;
    stage_v_d    = 1'b0;
    stage_addr_d = stage_addr_q;
    stage_data_d = stage_data_q;
    if (!capture) begin
      pack_d = '0;
    end else if (in_range) begin
      if (o_x_i[3:0] == 4'hF) begin
        stage_v_d    = 1'b1;
        stage_addr_d = word_addr;
        stage_data_d = {o_data_i, pack_q[WORD_W-2:0]};
        pack_d       = '0;
      end else begin
        pack_d[o_x_i[3:0]] = o_data_i;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge o_clk_i) begin
    if (reset_i) begin
      pack_q       <= '0;
      stage_v_q    <= 1'b0;
      stage_addr_q <= '0;
      stage_data_q <= '0;
    end else begin
      pack_q       <= pack_d;
      stage_v_q    <= stage_v_d;
      stage_addr_q <= stage_addr_d;
      stage_data_q <= stage_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [WORD_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [3:0]        count_q, count_d;
  logic              overflow_q;
  logic              pop;
  logic              push_ok;

  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign push_ok = stage_v_q & ((count_q != FULL_LVL) | pop);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage array carries no reset; occupancy is governed by the pointers and count.
  always_ff @(posedge o_clk_i) begin
    if (push_ok) begin
      fifo_addr_q[wr_ptr_q] <= stage_addr_q;
      fifo_data_q[wr_ptr_q] <= stage_data_q;
    end
  end

  always_ff @(posedge o_clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (stage_v_q && !push_ok) overflow_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              frame_done_q, frame_done_d;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    data_d       = data_q;
    pop          = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != 4'd0) begin
          addr_d  = fifo_addr_q[rd_ptr_q];
          data_d  = fifo_data_q[rd_ptr_q];
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (wr_ack_i) begin
          pop          = 1'b1;
          req_d        = 1'b0;
          frame_done_d = (addr_q == LAST_ADDR);
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge o_clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_req_o     = req_q;
  assign wr_addr_o    = addr_q;
  assign wr_data_o    = data_q;
  assign fifo_level_o = count_q;
  assign overflow_o   = overflow_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_o_pixel_packer.sv
// Randomized self-checking bench for o_pixel_packer; expected writes are derived
// from the driven line images with plain arithmetic and compared in order.
module tb_o_pixel_packer;

  logic        o_clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        enable_i = 1'b0;
  logic [9:0]  o_x_i = '0;
  logic [8:0]  o_y_i = '0;
  logic        o_visible_i = 1'b0;
  logic        o_data_i = 1'b0;
  logic        wr_req_o;
  logic [13:0] wr_addr_o;
  logic [15:0] wr_data_o;
  logic        wr_ack_i = 1'b0;
  logic [3:0]  fifo_level_o;
  logic        overflow_o;
  logic        frame_done_o;

  o_pixel_packer dut (
    .o_clk_i      (o_clk_i),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .o_x_i        (o_x_i),
    .o_y_i        (o_y_i),
    .o_visible_i  (o_visible_i),
    .o_data_i     (o_data_i),
    .wr_req_o     (wr_req_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .wr_ack_i     (wr_ack_i),
    .fifo_level_o (fifo_level_o),
    .overflow_o   (overflow_o),
    .frame_done_o (frame_done_o)
  );

  always #5 o_clk_i = ~o_clk_i;

  int n_vec = 0;
  int n_bad = 0;
  int ack_mode = 0;       // 0: never ack, 1: always ack, 2: random ack
  int n_writes = 0;
  int fd_count = 0;
  bit fd_expect = 1'b0;
  logic [29:0] exp_q [$];  // {addr, data} in expected write order

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge o_clk_i);
    #1;
  endtask

  always @(posedge o_clk_i) begin
    #1;
    case (ack_mode)
      1:       wr_ack_i = 1'b1;
      2:       wr_ack_i = 1'($urandom_range(0, 1));
      default: wr_ack_i = 1'b0;
    endcase
  end

  // Handshake monitor: a write is taken when REQ and ACK are both high across an edge.
  always @(negedge o_clk_i) begin
    if (!reset_i) begin
      if (frame_done_o) fd_count++;
      if (fd_expect) begin
        check("frame_done_pulse", 32'(frame_done_o), 32'd1);
        fd_expect = 1'b0;
      end
      if (wr_req_o && wr_ack_i) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          check("write_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [29:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr_o), 32'(e[29:16]));
          check("wr_data", 32'(wr_data_o), 32'(e[15:0]));
        end
        if (wr_addr_o == 14'd13607) fd_expect = 1'b1;
      end
    end
  end

  task automatic put(input int x, input int y, input bit vis, input bit en, input bit d);
    o_x_i       = 10'(x);
    o_y_i       = 9'(y);
    o_visible_i = vis;
    enable_i    = en;
    o_data_i    = d;
    tick();
  endtask

  task automatic idle_inputs();
    o_visible_i = 1'b0;
    enable_i    = 1'b1;
    o_data_i    = 1'b0;
  endtask

  task automatic drive_line(input int y, input logic [575:0] bits, input int vis_lo, input int vis_hi);
    for (int x = 0; x < 576; x++)
      put(x, y, !(x >= vis_lo && x <= vis_hi), 1'b1, bits[x]);
    idle_inputs();
  endtask

  task automatic expect_words(input int y, input logic [575:0] bits, input int first,
                              input int last, input int skip);
    for (int k = first; k <= last; k++)
      if (k != skip) exp_q.push_back({14'(y * 36 + k), bits[16*k +: 16]});
  endtask

  function automatic logic [575:0] rand_line();
    logic [575:0] b;
    for (int i = 0; i < 18; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_level_o != 0 || wr_req_o) && n < 3000) begin
      tick();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    exp_q.delete();
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  initial begin
    logic [575:0] bits;
    logic [15:0]  p;
    int           n;
    int           w0;

    do_reset();
    check("rst_req",        32'(wr_req_o),     32'd0);
    check("rst_addr",       32'(wr_addr_o),    32'd0);
    check("rst_data",       32'(wr_data_o),    32'd0);
    check("rst_level",      32'(fifo_level_o), 32'd0);
    check("rst_overflow",   32'(overflow_o),   32'd0);
    check("rst_frame_done", 32'(frame_done_o), 32'd0);

    // Single word at y=0 with pixels 0 and 15 set; REQ rises two edges after x=15.
    ack_mode = 1;
    exp_q.push_back({14'd0, 16'h8001});
    for (int x = 0; x < 16; x++) put(x, 0, 1'b1, 1'b1, (x == 0 || x == 15));
    idle_inputs();
    check("lat_req_n0", 32'(wr_req_o), 32'd0);
    tick();
    check("lat_req_n1", 32'(wr_req_o), 32'd0);
    check("lat_level_n1", 32'(fifo_level_o), 32'd1);
    tick();
    check("lat_req_n2", 32'(wr_req_o), 32'd1);
    drain("drain_t1");

    // Last word of line 2, all ones.
    exp_q.push_back({14'd107, 16'hFFFF});
    for (int x = 560; x < 576; x++) put(x, 2, 1'b1, 1'b1, 1'b1);
    idle_inputs();
    drain("drain_t2");

    // Out-of-window coordinates must not produce writes.
    put(607, 0, 1'b1, 1'b1, 1'b1);
    put(15, 400, 1'b1, 1'b1, 1'b1);
    idle_inputs();
    repeat (6) tick();
    drain("drain_oob");

    // Visibility lost at x=9 of word 3: that word is never written.
    bits = rand_line();
    bits[48 +: 9] = 9'h1FF;
    expect_words(5, bits, 0, 35, 3);
    drive_line(5, bits, 57, 63);
    drain("drain_t4");

    // Enable dropped mid-word: earlier bits are discarded, the rest completes the word.
    p = 16'($urandom());
    exp_q.push_back({14'(6 * 36), p & 16'hFFC0});
    for (int x = 0; x < 16; x++)
      put(x, 6, 1'b1, !(x >= 3 && x <= 5), (x < 3) ? 1'b1 : p[x]);
    idle_inputs();
    drain("drain_clear");

    // Random line data with random ACK timing.
    ack_mode = 2;
    for (int y = 100; y < 102; y++) begin
      bits = rand_line();
      expect_words(y, bits, 0, 35, -1);
      drive_line(y, bits, -1, -1);
    end
    drain("drain_rand");

    // ACK withheld across a full line: 8 words kept, the rest dropped.
    ack_mode = 0;
    bits = rand_line();
    expect_words(10, bits, 0, 7, -1);
    drive_line(10, bits, -1, -1);
    repeat (3) tick();
    check("ovf_level", 32'(fifo_level_o), 32'd8);
    check("ovf_flag",  32'(overflow_o),   32'd1);
    check("ovf_req",   32'(wr_req_o),     32'd1);
    ack_mode = 2;
    drain("drain_ovf");
    check("ovf_sticky", 32'(overflow_o), 32'd1);
    do_reset();
    check("ovf_cleared", 32'(overflow_o), 32'd0);

    // Reset in the middle of a pending handshake abandons the write.
    ack_mode = 0;
    exp_q.push_back({14'(7 * 36), 16'h0000});
    for (int x = 0; x < 16; x++) put(x, 7, 1'b1, 1'b1, 1'b0);
    idle_inputs();
    n = 0;
    while (!wr_req_o && n < 50) begin
      tick();
      n++;
    end
    check("mid_req_seen", 32'(wr_req_o), 32'd1);
    w0 = n_writes;
    reset_i = 1'b1;
    exp_q.delete();
    tick();
    check("mid_rst_req",   32'(wr_req_o),     32'd0);
    check("mid_rst_level", 32'(fifo_level_o), 32'd0);
    reset_i = 1'b0;
    ack_mode = 1;
    repeat (30) tick();
    check("mid_no_writes", 32'(n_writes - w0), 32'd0);

    // Last two lines of the frame: FRAME_DONE pulses once after address 13607.
    fd_count = 0;
    for (int y = 376; y < 378; y++) begin
      bits = rand_line();
      expect_words(y, bits, 0, 35, -1);
      drive_line(y, bits, -1, -1);
    end
    drain("drain_frame");
    repeat (4) tick();
    check("frame_done_count", 32'(fd_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
